clock_switch_ctrl: RTL and testbench

- Sequenced, parametrised controller for the crypto-clock source mux and the clock-output enable; runs on the USB clock domain.
- Selects one of NUM_SRC clock sources, from either register bits or DIP switches.
- Every source change is sequenced as: gate output off -> change mux select -> wait for settle -> restore output enable.
- Rejects requests for invalid or absent sources and counts completed switches for firmware readback.

---
 rtl/clock_switch_ctrl.sv | 133 +++++++++++++
 tb/tb_clock_switch_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_ctrl.sv
// Sequenced clock-source switch controller: gates the output, moves the mux select,
// waits for the new clock to settle, then restores the output enable.
module clock_switch_ctrl #(
    parameter int NUM_SRC       = 4,
    parameter int SEL_W         = 2,
    parameter int DEFAULT_SRC   = 0,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               usb_clk,
    input  logic               reset,
    input  logic               I_reg_mode,
    input  logic [SEL_W-1:0]   I_reg_src,
    input  logic               I_reg_out_en,
    input  logic [SEL_W-1:0]   I_dip_src,
    input  logic               I_dip_out_en,
    input  logic [NUM_SRC-1:0] I_src_valid,
    output logic [SEL_W-1:0]   O_src_sel,
    output logic               O_out_en,
    output logic               O_busy,
    output logic               O_err,
    output logic [7:0]         O_switch_cnt,
    output logic [1:0]         O_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GATE   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int CNT_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] RESET_SRC   = SEL_W'(DEFAULT_SRC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [SEL_W-1:0] src_sel_d;
    logic             out_en_d, busy_d, err_d;
    logic [7:0]       switch_cnt_d;

    logic [SEL_W-1:0] req_src;
    logic             req_oe, req_ok, switch_req;

    // Out-of-range sources never match any index, so they read as invalid.
    always_comb begin
        req_src = I_reg_mode ? I_reg_src : I_dip_src;
        req_oe  = I_reg_mode ? I_reg_out_en : I_dip_out_en;
        req_ok  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_src == SEL_W'(i)) req_ok = I_src_valid[i];
        end
        switch_req = req_ok && (req_src != O_src_sel);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        src_sel_d    = O_src_sel;
        out_en_d     = O_out_en;
        err_d        = O_err;
        switch_cnt_d = O_switch_cnt;
        case (state_q)
            ST_RUN: begin
                err_d = !req_ok;
                if (switch_req) begin
                    target_d = req_src;
                    out_en_d = 1'b0;
                    cnt_d    = GATE_LOAD;
                    state_d  = ST_GATE;
                end else begin
                    out_en_d = req_oe;
                end
            end
            ST_GATE: begin
                out_en_d = 1'b0;
                if (cnt_q == '0) begin
                    src_sel_d    = target_q;
                    switch_cnt_d = O_switch_cnt + 8'd1;
                    cnt_d        = SETTLE_LOAD;
                    state_d      = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                out_en_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d  = ST_RUN;
                    // A request queued during the sequence keeps the output gated
                    // straight into the next sequence instead of a one-cycle glitch.
                    out_en_d = req_oe && !switch_req;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                out_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            target_q     <= RESET_SRC;
            O_src_sel    <= RESET_SRC;
            O_out_en     <= 1'b0;
            O_busy       <= 1'b0;
            O_err        <= 1'b0;
            O_switch_cnt <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            O_src_sel    <= src_sel_d;
            O_out_en     <= out_en_d;
            O_busy       <= busy_d;
            O_err        <= err_d;
            O_switch_cnt <= switch_cnt_d;
        end
    end

    assign O_dbg_state = state_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl (GATE=4, SETTLE=8): expected output words are
// queued from the documented latencies and compared one cycle-step at a time.
module tb_clock_switch_ctrl;

    logic       usb_clk = 1'b0;
    logic       reset;
    logic       I_reg_mode;
    logic [1:0] I_reg_src;
    logic       I_reg_out_en;
    logic [1:0] I_dip_src;
    logic       I_dip_out_en;
    logic [3:0] I_src_valid;
    logic [1:0] O_src_sel;
    logic       O_out_en;
    logic       O_busy;
    logic       O_err;
    logic [7:0] O_switch_cnt;
    logic [1:0] O_dbg_state;

    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    clock_switch_ctrl #(
        .NUM_SRC(4), .SEL_W(2), .DEFAULT_SRC(0), .GATE_CYCLES(4), .SETTLE_CYCLES(8)
    ) dut (
        .usb_clk(usb_clk), .reset(reset),
        .I_reg_mode(I_reg_mode), .I_reg_src(I_reg_src), .I_reg_out_en(I_reg_out_en),
        .I_dip_src(I_dip_src), .I_dip_out_en(I_dip_out_en), .I_src_valid(I_src_valid),
        .O_src_sel(O_src_sel), .O_out_en(O_out_en), .O_busy(O_busy), .O_err(O_err),
        .O_switch_cnt(O_switch_cnt), .O_dbg_state(O_dbg_state)
    );

    always #5 usb_clk = ~usb_clk;

    // Advance one clock and settle just past the active edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge usb_clk);
            #1;
        end
    endtask

    // Expected word: {sel[1:0], oe, busy, err, cnt[7:0]}
    task automatic push_exp(input logic [1:0] sel, input logic oe, input logic busy,
                            input logic err, input logic [7:0] cnt);
        exp_q.push_back({3'b000, sel, oe, busy, err, cnt});
    endtask

    task automatic check_outs(input string tag);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {3'b000, O_src_sel, O_out_en, O_busy, O_err, O_switch_cnt};
        exp = exp_q.pop_front();
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed sel/oe/busy/err/cnt=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_oe(input string tag, input logic exp_oe);
        logic [15:0] exp;
        exp_q.push_back({15'd0, exp_oe});
        exp = exp_q.pop_front();
        total++;
        assert ({15'd0, O_out_en} === exp)
        else begin
            bad++;
            $error("FAIL %s observed oe=%b expected=%b", tag, O_out_en, exp[0]);
        end
    endtask

    initial begin
        logic [1:0] cur;
        logic [1:0] nxt;

        reset        = 1'b1;
        I_reg_mode   = 1'b0;
        I_reg_src    = 2'd0;
        I_reg_out_en = 1'b0;
        I_dip_src    = 2'd0;
        I_dip_out_en = 1'b1;
        I_src_valid  = 4'hF;
        step(3);
        push_exp(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_outs("reset_values");

        reset = 1'b0;
        #1;
        push_exp(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_outs("release_gated");
        step(1);
        push_exp(2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_outs("dip_oe_rise");

        // Register mode, same source: no sequence.
        I_reg_mode   = 1'b1;
        I_reg_src    = 2'd0;
        I_reg_out_en = 1'b1;
        step(1);
        push_exp(2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_outs("reg_mode_same");

        // Switch 0 -> 2.
        I_reg_src = 2'd2;
        step(1);
        push_exp(2'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        check_outs("sw2_gate_start");
        step(3);
        push_exp(2'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        check_outs("sw2_gate_end");
        step(1);
        push_exp(2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
        check_outs("sw2_sel_change");
        step(7);
        push_exp(2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
        check_outs("sw2_settle_end");
        step(1);
        push_exp(2'd2, 1'b1, 1'b0, 1'b0, 8'd1);
        check_outs("sw2_restore");

        // Absent source 3: error, no gating, select held.
        I_reg_src   = 2'd3;
        I_src_valid = 4'b0111;
        step(1);
        push_exp(2'd2, 1'b1, 1'b0, 1'b1, 8'd1);
        check_outs("invalid_err");
        step(2);
        push_exp(2'd2, 1'b1, 1'b0, 1'b1, 8'd1);
        check_outs("invalid_hold");
        I_src_valid = 4'hF;
        step(1);
        push_exp(2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
        check_outs("valid_start");
        step(12);
        push_exp(2'd3, 1'b1, 1'b0, 1'b0, 8'd2);
        check_outs("sw3_restore");

        // Request to 0, then change to 1 during GATE: back-to-back sequences.
        I_reg_src = 2'd0;
        step(1);
        push_exp(2'd3, 1'b0, 1'b1, 1'b0, 8'd2);
        check_outs("chain_start");
        step(1);
        I_reg_src = 2'd1;
        step(3);
        push_exp(2'd0, 1'b0, 1'b1, 1'b0, 8'd3);
        check_outs("chain_first_target");
        for (int k = 6; k <= 12; k++) begin
            step(1);
            check_oe("chain_oe_gated", 1'b0);
        end
        step(1);
        push_exp(2'd0, 1'b0, 1'b0, 1'b0, 8'd3);
        check_outs("chain_run_cycle");
        step(1);
        push_exp(2'd0, 1'b0, 1'b1, 1'b0, 8'd3);
        check_outs("chain_second_start");
        for (int k = 15; k <= 25; k++) begin
            step(1);
            check_oe("chain_oe_gated2", 1'b0);
        end
        step(1);
        push_exp(2'd1, 1'b1, 1'b0, 1'b0, 8'd4);
        check_outs("chain_restore");

        // Enable-only toggles.
        I_reg_out_en = 1'b0;
        step(1);
        push_exp(2'd1, 1'b0, 1'b0, 1'b0, 8'd4);
        check_outs("oe_off");
        I_reg_out_en = 1'b1;
        #1;
        push_exp(2'd1, 1'b0, 1'b0, 1'b0, 8'd4);
        check_outs("oe_before_edge");
        step(1);
        push_exp(2'd1, 1'b1, 1'b0, 1'b0, 8'd4);
        check_outs("oe_on");

        // Reset asserted in SWITCH.
        I_reg_src = 2'd2;
        step(7);
        push_exp(2'd2, 1'b0, 1'b1, 1'b0, 8'd5);
        check_outs("mid_switch");
        reset = 1'b1;
        #1;
        push_exp(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_outs("reset_mid_seq");
        step(2);
        reset     = 1'b0;
        I_reg_src = 2'd0;
        step(1);
        push_exp(2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_outs("reset_recover");

        // 256 random switches: counter wraps to 0.
        cur = 2'd0;
        for (int i = 1; i <= 256; i++) begin
            nxt       = cur + 2'($urandom_range(1, 3));
            I_reg_src = nxt;
            cur       = nxt;
            step(13);
            push_exp(cur, 1'b1, 1'b0, 1'b0, 8'(i));
            check_outs("wrap_run");
        end

        // Back to DIP mode: a mode change is an ordinary request.
        I_reg_mode = 1'b0;
        I_dip_src  = (cur == 2'd0) ? 2'd1 : 2'd0;
        step(1);
        push_exp(cur, 1'b0, 1'b1, 1'b0, 8'd0);
        check_outs("dip_mode_start");
        step(12);
        push_exp(I_dip_src, 1'b1, 1'b0, 1'b0, 8'd1);
        check_outs("dip_mode_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
